// File: rtl/seq_restoring_divider.sv
// Iterative restoring divider: one quotient bit per clock via trial subtraction.
// Optional signed mode is enabled by defining DIV_SIGNED_EN (adds is_signed port and a FIX state).
module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] div_reg;
  logic [CW-1:0]    cnt;
  logic             zero_flag;

  logic [WIDTH:0]   shifted_rem;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] dvd_cap;
  logic [WIDTH-1:0] dsr_cap;

  // Remainder is kept one bit wider during the trial so a shifted value >= 2^WIDTH is not lost
  assign shifted_rem = {rem_reg, quo_reg[WIDTH-1]};
  assign trial       = shifted_rem - {1'b0, div_reg};

`ifdef DIV_SIGNED_EN
  logic             dvd_neg;
  logic             dsr_neg;
  logic             signed_reg;
  logic             q_neg;
  logic             r_neg;
  logic [WIDTH-1:0] raw_dvd;

  assign dvd_neg = is_signed & dividend[WIDTH-1];
  assign dsr_neg = is_signed & divisor[WIDTH-1];
  assign dvd_cap = dvd_neg ? (~dividend + 1'b1) : dividend;
  assign dsr_cap = dsr_neg ? (~divisor + 1'b1) : divisor;
`else
  assign dvd_cap = dividend;
  assign dsr_cap = divisor;
`endif

  // Main control FSM; all outputs are registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rem_reg   <= '0;
      quo_reg   <= '0;
      div_reg   <= '0;
      cnt       <= '0;
      zero_flag <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
`ifdef DIV_SIGNED_EN
      signed_reg <= 1'b0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      raw_dvd    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            rem_reg   <= '0;
            quo_reg   <= dvd_cap;
            div_reg   <= dsr_cap;
            cnt       <= CW'(WIDTH);
            zero_flag <= (divisor == '0);
            busy      <= 1'b1;
            state     <= CALC;
`ifdef DIV_SIGNED_EN
            signed_reg <= is_signed;
            q_neg      <= dvd_neg ^ dsr_neg;
            r_neg      <= dvd_neg;
            raw_dvd    <= dividend;
`endif
          end
        end
        CALC: begin
          rem_reg <= trial[WIDTH] ? shifted_rem[WIDTH-1:0] : trial[WIDTH-1:0];
          quo_reg <= {quo_reg[WIDTH-2:0], ~trial[WIDTH]};
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
`ifdef DIV_SIGNED_EN
            state <= FIX;
`else
            state <= DONE;
`endif
          end
        end
`ifdef DIV_SIGNED_EN
        // Divide-by-zero bypasses sign correction so the raw dividend and all-ones quotient survive
        FIX: begin
          if (zero_flag) begin
            rem_reg <= raw_dvd;
          end else if (signed_reg) begin
            if (q_neg) quo_reg <= ~quo_reg + 1'b1;
            if (r_neg) rem_reg <= ~rem_reg + 1'b1;
          end
          state <= DONE;
        end
`endif
        DONE: begin
          quotient  <= quo_reg;
          remainder <= rem_reg;
          div_zero  <= zero_flag;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: stimulus pushes expected results, a monitor pops on done.
// Signed cases are exercised when DIV_SIGNED_EN is defined.
module tb_seq_restoring_divider;

  localparam int W = 8;
`ifdef DIV_SIGNED_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           cyc;
    string        tag;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         is_signed = 1'b0;
  logic         busy, done, div_zero;
  logic [W-1:0] quotient, remainder;

  exp_t sb[$];
  int   tests = 0;
  int   failed = 0;
  int   cyc = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
`ifdef DIV_SIGNED_EN
    .is_signed (is_signed),
`endif
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model from plain integer arithmetic
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    exp_t e;
    int   sa, sb_;
    int   qi, ri;
    e.dz = (b == 0);
    if (b == 0) begin
      e.q = '1;
      e.r = a;
    end else if (sgn) begin
      sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
      sb_ = b[W-1] ? int'(b) - (1 << W) : int'(b);
      qi = sa / sb_;
      ri = sa % sb_;
      e.q = W'(qi);
      e.r = W'(ri);
    end else begin
      e.q = W'(int'(a) / int'(b));
      e.r = W'(int'(a) % int'(b));
    end
    e.cyc = 0;
    e.tag = "";
    return e;
  endfunction

  // Waits for IDLE (busy low), issues one start and queues the expected result
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                               input string tag);
    exp_t e;
    int   guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput({tag, "_idle_timeout"}, 1, 0);
    dividend  = a;
    divisor   = b;
    is_signed = sgn;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e = model(a, b, sgn);
    e.cyc = cyc;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drainScoreboard(input string tag);
    int guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({tag, "_drain_left"}, sb.size(), 0);
  endtask

  // Monitor: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput({e.tag, "_quotient"}, quotient, e.q);
        checkOutput({e.tag, "_remainder"}, remainder, e.r);
        checkOutput({e.tag, "_div_zero"}, div_zero, e.dz);
        checkOutput({e.tag, "_latency"}, cyc - e.cyc, LAT);
        checkOutput({e.tag, "_busy_at_done"}, busy, 0);
      end
    end
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;

    #2;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_quotient", quotient, 0);
    checkOutput("reset_remainder", remainder, 0);
    checkOutput("reset_div_zero", div_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic division with busy profile check
    applyStimulus(8'd100, 8'd7, 1'b0, "d100_7");
    for (int i = 1; i <= W; i++) begin
      checkOutput($sformatf("busy_cycle%0d", i), busy, 1);
      checkOutput($sformatf("no_early_done%0d", i), done, 0);
      @(posedge clk);
      #1;
    end
    drainScoreboard("d100_7");

    // Back-to-back requests
    applyStimulus(8'd255, 8'd1, 1'b0, "d255_1");
    applyStimulus(8'd5, 8'd9, 1'b0, "d5_9");
    drainScoreboard("b2b");

    applyStimulus(8'd13, 8'd0, 1'b0, "d13_0");
    applyStimulus(8'd20, 8'd4, 1'b0, "d20_4");
    drainScoreboard("divzero");

    // Second start while busy must be ignored
    applyStimulus(8'd200, 8'd3, 1'b0, "d200_3");
    @(negedge clk);
    @(negedge clk);
    dividend = 8'd9;
    divisor  = 8'd9;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drainScoreboard("ignored_start");
    repeat (3) @(negedge clk);

    // Reset mid-calculation aborts without done
    applyStimulus(8'd200, 8'd3, 1'b0, "aborted");
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_quotient", quotient, 0);
    checkOutput("abort_remainder", remainder, 0);
    checkOutput("abort_div_zero", div_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    applyStimulus(8'd7, 8'd2, 1'b0, "d7_2");
    drainScoreboard("after_reset");

    // Results hold through IDLE
    repeat (4) @(negedge clk);
    checkOutput("hold_quotient", quotient, 3);
    checkOutput("hold_remainder", remainder, 1);

`ifdef DIV_SIGNED_EN
    applyStimulus(8'h9C, 8'd7, 1'b1, "s_m100_7");
    applyStimulus(8'h80, 8'hFF, 1'b1, "s_min_m1");
    applyStimulus(8'hF3, 8'd0, 1'b1, "s_divzero");
    applyStimulus(8'h9C, 8'd7, 1'b0, "u_156_7");
    drainScoreboard("signed");
`endif

    // Randomized back-to-back traffic
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(0, (1 << W) - 1));
`ifdef DIV_SIGNED_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      applyStimulus(ra, rb, rs, $sformatf("rand%0d", n));
    end
    drainScoreboard("random");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got 1, expected 0");
    $fatal(1, "[TB] timeout");
  end

endmodule
